// File: rtl/wb_port_arbiter_if.sv
// Write-port arbiter bus: pipe writeback request, long-latency push, RF write.
// slave = arbiter side, master = pipeline / long source / register file side.
interface wb_port_arbiter_if #(
  parameter int SIMD_DATA_WIDTH = 128,
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5
);
  logic                       Pipe_WbEn;
  logic                       Pipe_WbSel;
  logic [SIMD_DATA_WIDTH-1:0] Pipe_AluData;
  logic [DATA_WIDTH-1:0]      Pipe_DataRd;
  logic [REG_ADDR_WIDTH-1:0]  Pipe_Rd;
  logic                       Wb_Stall;
  logic                       Long_Valid;
  logic [REG_ADDR_WIDTH-1:0]  Long_Rd;
  logic [DATA_WIDTH-1:0]      Long_Data;
  logic                       Long_Ready;
  logic                       Reg_WrtEn;
  logic [REG_ADDR_WIDTH-1:0]  Reg_WrtAddr;
  logic [SIMD_DATA_WIDTH-1:0] Reg_WrtData;

  modport slave (
    input  Pipe_WbEn, Pipe_WbSel, Pipe_AluData,
    input  Pipe_DataRd, Pipe_Rd,
    input  Long_Valid, Long_Rd, Long_Data,
    output Wb_Stall, Long_Ready,
    output Reg_WrtEn, Reg_WrtAddr, Reg_WrtData
  );

  modport master (
    output Pipe_WbEn, Pipe_WbSel, Pipe_AluData,
    output Pipe_DataRd, Pipe_Rd,
    output Long_Valid, Long_Rd, Long_Data,
    input  Wb_Stall, Long_Ready,
    input  Reg_WrtEn, Reg_WrtAddr, Reg_WrtData
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single RF write port between MemWb writeback and a buffered
// long-latency result FIFO. Ports: clk, rst_n (sync, active-low), bus (slave).
`ifndef WB_ALU
`define WB_ALU 1'b1
`endif

module wb_port_arbiter #(
  parameter int SIMD_DATA_WIDTH = 128,
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_WAIT        = 4
) (
  input logic           clk,
  input logic           rst_n,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [REG_ADDR_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     fifo_data [FIFO_DEPTH];
  logic [AW-1:0]             rd_ptr;
  logic [AW-1:0]             wr_ptr;
  logic [CW-1:0]             count;
  logic [WW-1:0]             wait_cnt;

  logic pipe_req;
  logic empty;
  logic full;
  logic conflict;
  logic grant_fifo;
  logic grant_pipe;
  logic push;

  assign pipe_req = bus.Pipe_WbEn & (|bus.Pipe_Rd);
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CW'(i) < count) &&
          (fifo_rd[rd_ptr + AW'(i)] == bus.Pipe_Rd))
        conflict = 1'b1;
    end
  end

  // Forced grant (full / starved / hazard) or idle slot goes to the FIFO.
  assign grant_fifo = !empty &
    (full | (wait_cnt >= WW'(MAX_WAIT)) |
     (pipe_req & conflict) | !pipe_req);
  assign grant_pipe = pipe_req & !grant_fifo;

  assign bus.Wb_Stall   = rst_n & pipe_req & grant_fifo;
  assign bus.Long_Ready = rst_n & !full;

  assign push = bus.Long_Valid & bus.Long_Ready & (|bus.Long_Rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      wait_cnt        <= '0;
      bus.Reg_WrtEn   <= 1'b0;
      bus.Reg_WrtAddr <= '0;
      bus.Reg_WrtData <= '0;
    end else begin
      bus.Reg_WrtEn <= grant_fifo | grant_pipe;
      if (grant_fifo) begin
        bus.Reg_WrtAddr <= fifo_rd[rd_ptr];
        bus.Reg_WrtData <= SIMD_DATA_WIDTH'(fifo_data[rd_ptr]);
      end else if (grant_pipe) begin
        bus.Reg_WrtAddr <= bus.Pipe_Rd;
        if (bus.Pipe_WbSel == `WB_ALU)
          bus.Reg_WrtData <= bus.Pipe_AluData;
        else
          bus.Reg_WrtData <= SIMD_DATA_WIDTH'(bus.Pipe_DataRd);
      end

      if (push) begin
        fifo_rd[wr_ptr]   <= bus.Long_Rd;
        fifo_data[wr_ptr] <= bus.Long_Data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (grant_fifo)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(grant_fifo);

      if (empty || grant_fifo)
        wait_cnt <= '0;
      else if (wait_cnt < WW'(MAX_WAIT))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter for the single register-file write port, placed after the MemWb stage. It shares the port between the in-order pipeline writeback and a long-latency result source (multi-cycle MDU / late load return). Long-latency results are buffered in a small FIFO. The arbiter applies the ALU/memory writeback select with zero-extension, stalls the pipeline when the port must go to buffered results, and drives a registered write port into the register file.

## Interface
- SIMD_DATA_WIDTH, 128, width of the write port and of ALU results
- DATA_WIDTH, 32, width of memory-read and long-latency results
- REG_ADDR_WIDTH, 5, register index width
- FIFO_DEPTH, 2, long-latency buffer entries (power of two, ≥2)
- MAX_WAIT, 4, cycles a non-empty FIFO head may wait before it is force-granted

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous and active-low
- Pipe_WbEn  in  1  pipeline writeback request (MemWb stage valid with register write)
- Pipe_WbSel  in  1  `WB_ALU selects Pipe_AluData; otherwise zero-extended Pipe_DataRd
- Pipe_AluData  in  SIMD_DATA_WIDTH  ALU/SIMD result
- Pipe_DataRd  in  DATA_WIDTH  memory read data
- Pipe_Rd  in  REG_ADDR_WIDTH  destination register
- Wb_Stall  out  1  holds the MemWb stage; combinational
- Long_Valid  in  1  long-latency result valid
- Long_Rd  in  REG_ADDR_WIDTH  destination register
- Long_Data  in  DATA_WIDTH  result, zero-extended on write
- Long_Ready  out  1  FIFO can accept; transfer on Long_Valid & Long_Ready
- Reg_WrtEn  out  1  register-file write enable (registered)
- Reg_WrtAddr  out  REG_ADDR_WIDTH  write address (registered)
- Reg_WrtData  out  SIMD_DATA_WIDTH  write data (registered)

## Operation
- Effective pipe request: PipeReq = Pipe_WbEn & (Pipe_Rd != 0). If Pipe_Rd == 0, the request completes immediately. It is never stalled, never written, and leaves the slot free.
- Long push: on Long_Valid & Long_Ready with Long_Rd != 0, push {Long_Rd, Long_Data}. With Long_Rd == 0 the handshake completes and the result is dropped.
- Long_Ready = rst_n & (count < FIFO_DEPTH). It depends only on registered state and does not see a pop in the same cycle.
- Conflict = PipeReq & (Pipe_Rd matches the Rd of any valid FIFO entry).
- Grant priority, evaluated every cycle:
  1. FIFO non-empty & (count == FIFO_DEPTH | WaitCnt >= MAX_WAIT | Conflict): grant FIFO head.
  2. Otherwise, if PipeReq: grant pipe.
  3. Otherwise, if FIFO non-empty: grant FIFO head.
  4. Otherwise: no write.
- Wb_Stall = PipeReq & (grant is FIFO). The pipe holds its inputs and is re-evaluated next cycle.
- Data: a pipe grant writes Pipe_AluData if Pipe_WbSel == `WB_ALU, else {zeros, Pipe_DataRd}. A FIFO grant writes {zeros, head data}.
- WaitCnt is cleared when the FIFO is empty or the FIFO is granted. Otherwise it increments when the FIFO is non-empty, saturating at MAX_WAIT.
- Pop and push may happen in the same cycle: count is unchanged and ordering stays FIFO. There is no bypass; a pushed entry is eligible from the next cycle.
- Reset (rst_n low at an edge):
  - FIFO emptied, count and WaitCnt cleared.
  - Reg_WrtEn/Reg_WrtAddr/Reg_WrtData all cleared to 0.
  - Wb_Stall and Long_Ready forced 0 while rst_n is low.
  - Buffered results are discarded even if reset arrives mid-operation.

## Timing
- Write latency: the grant in cycle N produces Reg_WrtEn/Addr/Data at the edge ending cycle N, visible in cycle N+1. Reg_WrtEn is 1 for exactly one cycle per granted write.
- Minimum long-result latency: push in cycle N, written at the output in N+2 (empty FIFO, no PipeReq in N+1).
- Wb_Stall is combinational from the pipe inputs and registered state in the same cycle. There is no combinational path from Long_Valid to Wb_Stall or Long_Ready.
- Throughput: one register write per cycle. A continuous PipeReq stream is interrupted at least once every MAX_WAIT+1 cycles while the FIFO is non-empty.

## Test plan
- Pipe only: PipeReq with Rd=5, WbSel=`WB_ALU, AluData=0x…DEADBEEF -> next cycle Reg_WrtEn=1, Addr=5, Data=AluData. Repeat with WbSel=MEM, DataRd=0x12345678 -> Data=0x0…012345678. Wb_Stall stays 0.
- Long in idle slot: Long_Valid with Rd=7, Data=0xA5 and no PipeReq -> Reg write of Addr 7, Data 0xA5, two cycles after the handshake.
- Starvation: FIFO holds Rd=3 under continuous PipeReq (distinct Rd) -> in the cycle WaitCnt==4, Wb_Stall=1 and Rd=3 is written. The pipe resumes the next cycle with no pipe write lost or duplicated.
- Full and conflict:
  - Two long pushes (Rd=8, Rd=9) fill the FIFO -> Long_Ready=0, head drained first, Wb_Stall=1 if PipeReq.
  - PipeReq with Rd=9 while Rd=9 is buffered -> stall until the Rd=9 FIFO entry is written, then the pipe Rd=9 is written after it.
- Zero-register and reset:
  - PipeReq with Rd=0 -> no write, no stall. Long push with Rd=0 -> handshake completes, count unchanged.
  - rst_n low with FIFO occupied -> next cycle count=0, all Reg outputs 0, Long_Ready=0 until rst_n returns high.
